alu_op_sequencer: RTL and testbench



---
 rtl/alu_op_sequencer.sv | 154 +++++++++++++++
 tb/tb_alu_op_sequencer.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/alu_op_sequencer.sv
// Sequences one ALU operation over the shared data bus: loads A and B, issues the opcode,
// captures the registered result/flags and returns them over a valid/ready response channel.
module alu_op_sequencer #(
    parameter int DATA_W = 32,
    parameter int OP_W   = 4,
    parameter int FLAG_W = 4,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              clk_rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [DATA_W-1:0] req_a,
    input  logic [DATA_W-1:0] req_b,
    input  logic [OP_W-1:0]   req_op,
    output logic [DATA_W-1:0] data,
    output logic              ld_a,
    output logic              ld_b,
    output logic              ld_f,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [FLAG_W-1:0] alu_flag,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_result,
    output logic [FLAG_W-1:0] rsp_flag,
    output logic              busy,
    output logic [CNT_W-1:0]  op_count
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD_A  = 3'd1,
        LOAD_B  = 3'd2,
        EXEC    = 3'd3,
        CAPTURE = 3'd4,
        RESP    = 3'd5
    } state_e;

    typedef struct packed {
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [OP_W-1:0]   op;
    } req_t;

    state_e              state_q, state_d;
    req_t                req_q, req_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                ld_a_q, ld_a_d;
    logic                ld_b_q, ld_b_d;
    logic                ld_f_q, ld_f_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]   rsp_result_q, rsp_result_d;
    logic [FLAG_W-1:0]   rsp_flag_q, rsp_flag_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   op_word;

    assign op_word = {{(DATA_W-OP_W){1'b0}}, req_q.op};

    always_ff @(posedge clk or posedge clk_rst) begin
        if (clk_rst) begin
            state_q      <= IDLE;
            req_q        <= '0;
            data_q       <= '0;
            ld_a_q       <= 1'b0;
            ld_b_q       <= 1'b0;
            ld_f_q       <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_result_q <= '0;
            rsp_flag_q   <= '0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            req_q        <= req_d;
            data_q       <= data_d;
            ld_a_q       <= ld_a_d;
            ld_b_q       <= ld_b_d;
            ld_f_q       <= ld_f_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_result_q <= rsp_result_d;
            rsp_flag_q   <= rsp_flag_d;
            cnt_q        <= cnt_d;
        end
    end

    // Bus and strobe registers are loaded with the values for the state being entered,
    // so they line up with state_q for the whole cycle.
    always_comb begin
        state_d      = state_q;
        req_d        = req_q;
        data_d       = data_q;
        ld_a_d       = 1'b0;
        ld_b_d       = 1'b0;
        ld_f_d       = 1'b0;
        rsp_valid_d  = rsp_valid_q;
        rsp_result_d = rsp_result_q;
        rsp_flag_d   = rsp_flag_q;
        cnt_d        = cnt_q;
        case (state_q)
            IDLE: begin
                data_d = '0;
                if (req_valid) begin
                    req_d   = '{a: req_a, b: req_b, op: req_op};
                    data_d  = req_a;
                    ld_a_d  = 1'b1;
                    state_d = LOAD_A;
                end
            end
            LOAD_A: begin
                data_d  = req_q.b;
                ld_b_d  = 1'b1;
                state_d = LOAD_B;
            end
            LOAD_B: begin
                data_d  = op_word;
                ld_f_d  = 1'b1;
                state_d = EXEC;
            end
            EXEC: begin
                data_d  = op_word;
                state_d = CAPTURE;
            end
            CAPTURE: begin
                rsp_result_d = alu_result;
                rsp_flag_d   = alu_flag;
                rsp_valid_d  = 1'b1;
                state_d      = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    cnt_d       = cnt_q + CNT_W'(1);
                    data_d      = '0;
                    state_d     = IDLE;
                end
            end
            default: begin
                data_d  = '0;
                state_d = IDLE;
            end
        endcase
    end

    assign req_ready  = (state_q == IDLE);
    assign busy       = (state_q != IDLE);
    assign data       = data_q;
    assign ld_a       = ld_a_q;
    assign ld_b       = ld_b_q;
    assign ld_f       = ld_f_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_result = rsp_result_q;
    assign rsp_flag   = rsp_flag_q;
    assign op_count   = cnt_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboard bench for alu_op_sequencer with a bus-driven ALU register model; a 2-bit
// counter makes the op_count wrap reachable.
module tb_alu_op_sequencer;
    localparam int DW = 32;
    localparam int OW = 4;
    localparam int FW = 4;
    localparam int CW = 2;

    logic          clk = 1'b0;
    logic          clk_rst = 1'b1;
    logic          req_valid, req_ready, rsp_valid, rsp_ready, busy;
    logic [DW-1:0] req_a, req_b, data, alu_result, rsp_result;
    logic [OW-1:0] req_op;
    logic          ld_a, ld_b, ld_f;
    logic [FW-1:0] alu_flag, rsp_flag;
    logic [CW-1:0] op_count;

    always #5 clk = ~clk;

    alu_op_sequencer #(.DATA_W(DW), .OP_W(OW), .FLAG_W(FW), .CNT_W(CW)) dut (
        .clk(clk), .clk_rst(clk_rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_op(req_op),
        .data(data), .ld_a(ld_a), .ld_b(ld_b), .ld_f(ld_f),
        .alu_result(alu_result), .alu_flag(alu_flag),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_flag(rsp_flag),
        .busy(busy), .op_count(op_count)
    );

    int                 n_vec = 0;
    int                 n_err = 0;
    logic [DW+FW-1:0]   exp_q[$];
    logic [DW-1:0]      cur_a, cur_b;
    logic [OW-1:0]      cur_op;
    int                 n_lda, n_ldb, n_ldf;
    logic [CW-1:0]      exp_cnt;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, act, exp);
        end
    endtask

    // Flags are {Z, N, C, V}.
    function automatic logic [DW+FW-1:0] alu(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                             input logic [OW-1:0] op);
        logic [DW:0] s;
        logic        v;
        v = 1'b0;
        case (op)
            4'h1, 4'hF: begin
                s = {1'b0, a} + {1'b0, b};
                v = (a[DW-1] == b[DW-1]) && (s[DW-1] != a[DW-1]);
            end
            4'h2:    s = {1'b0, a} - {1'b0, b};
            default: s = {1'b0, a ^ b};
        endcase
        return {s[DW-1:0], (s[DW-1:0] == '0), s[DW-1], s[DW], v};
    endfunction

    // Downstream operand/result registers as seen on the bus.
    logic [DW-1:0] ar, br;
    always @(posedge clk) begin
        if (ld_a) ar <= data;
        if (ld_b) br <= data;
        if (ld_f) {alu_result, alu_flag} <= alu(ar, br, data[OW-1:0]);
    end

    always @(negedge clk) begin
        if (!clk_rst) begin
            if (ld_a | ld_b | ld_f) chk("strobe_onehot", 64'($onehot({ld_a, ld_b, ld_f})), 64'd1);
            if (ld_a) begin n_lda++; chk("bus_a", data, cur_a); end
            if (ld_b) begin n_ldb++; chk("bus_b", data, cur_b); end
            if (ld_f) begin n_ldf++; chk("bus_op", data, {{(DW-OW){1'b0}}, cur_op}); end
        end
    end

    task automatic do_op(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [OW-1:0] op,
                         input logic [DW+FW-1:0] exp, input int hold, input bit mutate);
        int k;
        @(negedge clk);
        chk("req_ready_idle", req_ready, 1);
        cur_a = a; cur_b = b; cur_op = op;
        n_lda = 0; n_ldb = 0; n_ldf = 0;
        req_valid = 1'b1; req_a = a; req_b = b; req_op = op;
        exp_q.push_back(exp);
        @(posedge clk);
        #1 req_valid = 1'b0;
        k = 0;
        while (!rsp_valid && k < 20) begin
            @(negedge clk);
            k++;
            if (mutate && k == 2) begin
                req_valid = 1'b1; req_a = ~a; req_b = ~b; req_op = ~op;
            end
        end
        req_valid = 1'b0;
        chk("latency", k, 5);
        if (!rsp_valid) begin
            void'(exp_q.pop_front());
            return;
        end
        for (int i = 0; i < hold; i++) begin
            if (i == 1) begin
                req_valid = 1'b1; req_a = $urandom; req_b = $urandom; req_op = 4'h2;
            end
            @(negedge clk);
            chk("bp_valid", rsp_valid, 1);
            chk("bp_hold", {rsp_result, rsp_flag}, exp);
            chk("bp_req_ready", req_ready, 0);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        chk("rsp_data", {rsp_result, rsp_flag}, exp_q.pop_front());
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        exp_cnt++;
        @(negedge clk);
        chk("rsp_drop", rsp_valid, 0);
        chk("op_count", op_count, exp_cnt);
        chk("req_ready_back", req_ready, 1);
        chk("busy_idle", busy, 0);
        chk("strobe_counts", {n_lda[7:0], n_ldb[7:0], n_ldf[7:0]}, 24'h010101);
    endtask

    initial begin
        logic [OW-1:0] ops[4];
        logic [DW-1:0] ra, rb;
        int k;
        ops = '{4'h1, 4'h2, 4'h3, 4'h1};
        req_valid = 1'b0; req_a = '0; req_b = '0; req_op = '0; rsp_ready = 1'b0;
        exp_cnt = '0;
        #1;
        chk("rst_data", data, 0);
        chk("rst_strobes", {ld_a, ld_b, ld_f}, 0);
        chk("rst_rsp", {rsp_valid, rsp_result, rsp_flag}, 0);
        chk("rst_count", op_count, 0);
        chk("rst_ready_busy", {req_ready, busy}, 2'b10);
        @(negedge clk);
        clk_rst = 1'b0;

        do_op(32'h5, 32'h3, 4'h1, {32'h8, 4'b0000}, 0, 1'b0);
        do_op(32'h1234_5678, 32'h0F0F_0F0F, 4'h2, alu(32'h1234_5678, 32'h0F0F_0F0F, 4'h2), 10, 1'b0);
        do_op(32'hCAFE_0000, 32'h0000_BEEF, 4'h3, alu(32'hCAFE_0000, 32'h0000_BEEF, 4'h3), 2, 1'b1);

        // Reset while EXEC is on the bus: the operation must vanish.
        @(negedge clk);
        cur_a = 32'hAAAA_0001; cur_b = 32'h5555_0002; cur_op = 4'h1;
        req_valid = 1'b1; req_a = cur_a; req_b = cur_b; req_op = cur_op;
        @(posedge clk);
        #1 req_valid = 1'b0;
        k = 0;
        while (!ld_f && k < 10) begin @(negedge clk); k++; end
        chk("reach_exec", ld_f, 1);
        #1 clk_rst = 1'b1;
        #1;
        chk("midrst_data", data, 0);
        chk("midrst_strobes", {ld_a, ld_b, ld_f}, 0);
        chk("midrst_rsp", {rsp_valid, rsp_result, rsp_flag}, 0);
        chk("midrst_count", op_count, 0);
        chk("midrst_ready_busy", {req_ready, busy}, 2'b10);
        exp_cnt = '0;
        @(negedge clk);
        clk_rst = 1'b0;
        k = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (rsp_valid) k++;
        end
        chk("midrst_no_rsp", k, 0);

        // Five operations walk the 2-bit counter through 1,2,3,0,1.
        do_op(32'hFFFF_FFFF, 32'h0000_0001, 4'hF, {32'h0, 4'b1010}, 1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            ra = $urandom; rb = $urandom;
            do_op(ra, rb, ops[i], alu(ra, rb, ops[i]), i, (i == 2));
        end

        chk("sb_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
